// File: rtl/soc_perf_pkg.sv
// Shared definitions for the SoC performance monitor.
//   perf_state_e  : monitor FSM encoding (IDLE=0, RUN=1, FROZEN=2)
//   ADDR_*        : read-port register map
//   CNT_*         : index of each counter inside the counter array
//   NOP_ENC       : canonical RV32 NOP (addi x0,x0,0), not counted as retired
//   cnt_addr()    : maps a counter array index to its read address
package soc_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } perf_state_e;

  localparam int ADDR_CYCLES   = 0;
  localparam int ADDR_INSTRET  = 1;
  localparam int ADDR_STALLS   = 2;
  localparam int ADDR_STATUS   = 3;
  localparam int ADDR_EVT_BASE = 4;

  localparam int CNT_CYCLES   = 0;
  localparam int CNT_INSTRET  = 1;
  localparam int CNT_STALLS   = 2;
  localparam int CNT_EVT_BASE = 3;

  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

  // The status register sits between the fixed counters and the event
  // counters in the address map, so event counters are shifted by one.
  function automatic int cnt_addr(input int idx);
    if (idx < CNT_EVT_BASE) return ADDR_CYCLES + idx;
    return ADDR_EVT_BASE + (idx - CNT_EVT_BASE);
  endfunction

endpackage

// File: rtl/soc_perf_monitor_sat_counter.sv
// perf_sat_counter: saturating up-counter with sticky overflow flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of value and ovf (wins over inc)
//   inc        : count request for this cycle
//   value      : current count, sticks at all-ones
//   ovf        : set when an increment arrives while value is all-ones
module perf_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         ovf
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (&value) ovf <= 1'b1;
      else        value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/soc_perf_monitor.sv
// soc_perf_monitor: performance counters and hang watchdog tapping the core
// debug bus.
//   clk, rst_n      : clock, asynchronous active-low reset
//   enable          : level, run counting (IDLE <-> RUN)
//   clear           : pulse, zero counters/status and return to IDLE
//   debug_pc/instr  : core PC and instruction being observed
//   debug_stall     : core stall indicator
//   evt_in          : generic event strobes, one count per high cycle
//   wdt_limit       : watchdog timeout in RUN cycles, 0 disables
//   rd_en, rd_addr  : read request and register select
//   rd_data         : registered read data
//   rd_valid        : one-cycle pulse marking rd_data as fresh
//   state           : FSM state (debug visibility)
//   halt_detected   : sticky tight-loop flag
//   wdt_expired     : sticky watchdog flag
//   irq             : halt_detected | wdt_expired
//
// Read handshake: rd_en has no backpressure. A request sampled at edge N
// returns, after edge N, the register value as it stood before edge N's
// update, with rd_valid high for exactly the following cycle. A request may
// be issued every cycle.
module soc_perf_monitor
  import soc_perf_pkg::*;
#(
  parameter int          CNT_W     = 32,
  parameter int          N_EVT     = 4,
  parameter int          WDT_W     = 20,
  parameter int          STABLE_TH = 5,
  parameter logic [31:0] NOP_INSTR = NOP_ENC,
  localparam int         RD_AW     = $clog2(N_EVT + 4)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [31:0]      debug_pc,
  input  logic [31:0]      debug_instr,
  input  logic             debug_stall,
  input  logic [N_EVT-1:0] evt_in,
  input  logic [WDT_W-1:0] wdt_limit,
  input  logic             rd_en,
  input  logic [RD_AW-1:0] rd_addr,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [1:0]       state,
  output logic             halt_detected,
  output logic             wdt_expired,
  output logic             irq
);

  localparam int NC     = CNT_EVT_BASE + N_EVT;
  localparam int STAT_W = NC + 4;
  localparam int SW     = $clog2(STABLE_TH + 1);
  localparam int SN     = (STAT_W < CNT_W) ? STAT_W : CNT_W;

  perf_state_e      cur_state, nxt_state;
  logic             run;
  logic             halt_evt, wdt_evt;
  logic             pc_match;
  logic [SW-1:0]    stable_cnt;
  logic [WDT_W-1:0] wdt_cnt;
  logic [WDT_W:0]   wdt_next_ext;
  logic [31:0]      prev_pc, prev_instr;
  logic             instret_cond;

  logic [NC-1:0]    cnt_inc;
  logic [NC-1:0]    cnt_ovf;
  logic [CNT_W-1:0] cnt_val [NC];

  logic [STAT_W-1:0] status_full;
  logic [CNT_W-1:0]  status_word;
  logic [CNT_W-1:0]  rd_mux;

  assign run          = (cur_state == ST_RUN);
  assign pc_match     = (debug_pc == prev_pc) && (debug_instr == prev_instr);
  assign instret_cond = !debug_stall && (debug_instr != NOP_INSTR) && (debug_instr != '0);

  // Halt fires one edge after stable_cnt has reached the threshold.
  assign halt_evt = run && (stable_cnt >= SW'(STABLE_TH));

  // Compare wdt_cnt+1 in one extra bit so a saturated counter cannot wrap
  // into a spurious match.
  assign wdt_next_ext = {1'b0, wdt_cnt} + {{WDT_W{1'b0}}, 1'b1};
  assign wdt_evt      = run && (wdt_limit != '0) && (wdt_next_ext == {1'b0, wdt_limit});

  assign cnt_inc = {evt_in & {N_EVT{run}}, run && debug_stall, run && instret_cond, run};

  for (genvar g = 0; g < NC; g++) begin : g_cnt
    perf_sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .inc   (cnt_inc[g]),
      .value (cnt_val[g]),
      .ovf   (cnt_ovf[g])
    );
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= ST_IDLE;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    if (clear) begin
      nxt_state = ST_IDLE;
    end else begin
      case (cur_state)
        ST_IDLE:   if (enable) nxt_state = ST_RUN;
        ST_RUN: begin
          if (halt_evt || wdt_evt) nxt_state = ST_FROZEN;
          else if (!enable)        nxt_state = ST_IDLE;
        end
        ST_FROZEN: nxt_state = ST_FROZEN;
        default:   nxt_state = ST_IDLE;
      endcase
    end
  end

  assign state = cur_state;

  // Halt detector, watchdog and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt    <= '0;
      wdt_cnt       <= '0;
      prev_pc       <= '0;
      prev_instr    <= '0;
      halt_detected <= 1'b0;
      wdt_expired   <= 1'b0;
      irq           <= 1'b0;
    end else if (clear) begin
      stable_cnt    <= '0;
      wdt_cnt       <= '0;
      prev_pc       <= '0;
      prev_instr    <= '0;
      halt_detected <= 1'b0;
      wdt_expired   <= 1'b0;
      irq           <= 1'b0;
    end else begin
      if (run) begin
        if (!(&wdt_cnt)) wdt_cnt <= wdt_cnt + 1'b1;
        // instr == 0 means the debug bus carries nothing; keep history.
        if (debug_instr != '0) begin
          if (!pc_match)                         stable_cnt <= '0;
          else if (stable_cnt != SW'(STABLE_TH)) stable_cnt <= stable_cnt + 1'b1;
          prev_pc    <= debug_pc;
          prev_instr <= debug_instr;
        end
      end
      halt_detected <= halt_detected | halt_evt;
      wdt_expired   <= wdt_expired | wdt_evt;
      irq           <= halt_detected | halt_evt | wdt_expired | wdt_evt;
    end
  end

  // Read port
  assign status_full = {cnt_ovf, wdt_expired, halt_detected, cur_state};

  always_comb begin
    status_word         = '0;
    status_word[SN-1:0] = status_full[SN-1:0];
  end

  always_comb begin
    rd_mux = '0;
    if (int'(rd_addr) == ADDR_STATUS) rd_mux = status_word;
    for (int j = 0; j < NC; j++) begin
      if (int'(rd_addr) == cnt_addr(j)) rd_mux = cnt_val[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule
